fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the async FIFO: issues reads, absorbs the 1-cycle read latency
// in a 2-entry skid buffer and emits a burst-framed valid/ready stream. Optional: FIFO_RD_COUNT_EN.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 16
) (
    input  logic             rdclk,
    input  logic             reset,
    input  logic             en,
    output logic             fifo_re,
    input  logic [WIDTH-1:0] fifo_dataout,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             idle
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [31:0]      rd_count,
    input  logic             cnt_clr
`endif
);

    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    logic [1:0]       occ;
    logic             pend;
    logic             head;
    logic             tail;
    logic [15:0]      bcnt;
    logic [WIDTH-1:0] entry [2];

    logic             pop;
    logic             push;
    logic [2:0]       level;

    assign pop  = out_valid & out_ready;
    assign push = pend;

    // Words owed to the buffer after this cycle's pop; reading only while below 2
    // means an in-flight word always has a slot, and out_ready feeds fifo_re directly.
    assign level   = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign fifo_re = !reset & en & !fifo_empty & (level < 3'd2);

    assign out_valid = (occ != 2'd0);
    assign out_data  = entry[head];
    assign out_last  = out_valid & (bcnt == LAST_IDX);
    assign idle      = (occ == 2'd0) & !pend;

    always_ff @(posedge rdclk) begin
        if (reset) begin
            occ      <= 2'd0;
            pend     <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
            bcnt     <= 16'd0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            pend <= fifo_re;
            if (push) begin
                entry[tail] <= fifo_dataout;
                tail        <= ~tail;
            end
            if (pop) begin
                head <= ~head;
                bcnt <= (bcnt == LAST_IDX) ? 16'd0 : bcnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // A returning word must never find the buffer full without a pop making room.
    assert property (@(posedge rdclk) disable iff (reset) !(pend && (occ == 2'd2) && !pop));

`ifdef FIFO_RD_COUNT_EN
    always_ff @(posedge rdclk) begin
        if (reset || cnt_clr) begin
            rd_count <= 32'd0;
        end else if (pop) begin
            rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule
